// File: rtl/ysyx_25040109_axi_pkg.sv
// ============================================================================
// ysyx_25040109_axi_pkg : shared AXI widths, response codes, arbiter states
// Rev 1.0
// ============================================================================
`default_nettype none

package ysyx_25040109_axi_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;
  localparam int STRB_W  = 4;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040109_rr_pick2.sv
// ============================================================================
// ysyx_25040109_rr_pick2 : two-way round-robin picker, one-hot grant
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_25040109_rr_pick2
  import ysyx_25040109_axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last=1 means requester 1 won most recently, so requester 0 goes first
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040109_axi_arbiter.sv
// ============================================================================
// ysyx_25040109_axi_arbiter : IFU/LSU onto one AXI4 master port, one in flight
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_25040109_axi_arbiter
  import ysyx_25040109_axi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ifu_arvalid,
  input  logic [ADDR_W-1:0]    ifu_araddr,
  input  logic [ID_W-1:0]      ifu_arid,
  input  logic [LEN_W-1:0]     ifu_arlen,
  input  logic [SIZE_W-1:0]    ifu_arsize,
  input  logic [BURST_W-1:0]   ifu_arburst,
  output logic                 ifu_arready,
  output logic                 ifu_rvalid,
  output logic [DATA_W-1:0]    ifu_rdata,
  output logic [RESP_W-1:0]    ifu_rresp,
  output logic [ID_W-1:0]      ifu_rid,
  output logic                 ifu_rlast,
  input  logic                 ifu_rready,

  input  logic                 lsu_arvalid,
  input  logic [ADDR_W-1:0]    lsu_araddr,
  input  logic [ID_W-1:0]      lsu_arid,
  input  logic [LEN_W-1:0]     lsu_arlen,
  input  logic [SIZE_W-1:0]    lsu_arsize,
  input  logic [BURST_W-1:0]   lsu_arburst,
  output logic                 lsu_arready,
  output logic                 lsu_rvalid,
  output logic [DATA_W-1:0]    lsu_rdata,
  output logic [RESP_W-1:0]    lsu_rresp,
  output logic [ID_W-1:0]      lsu_rid,
  output logic                 lsu_rlast,
  input  logic                 lsu_rready,

  input  logic                 lsu_awvalid,
  input  logic [ADDR_W-1:0]    lsu_awaddr,
  input  logic [ID_W-1:0]      lsu_awid,
  input  logic [LEN_W-1:0]     lsu_awlen,
  input  logic [SIZE_W-1:0]    lsu_awsize,
  input  logic [BURST_W-1:0]   lsu_awburst,
  output logic                 lsu_awready,
  input  logic                 lsu_wvalid,
  input  logic [DATA_W-1:0]    lsu_wdata,
  input  logic [STRB_W-1:0]    lsu_wstrb,
  input  logic                 lsu_wlast,
  output logic                 lsu_wready,
  output logic                 lsu_bvalid,
  output logic [RESP_W-1:0]    lsu_bresp,
  output logic [ID_W-1:0]      lsu_bid,
  input  logic                 lsu_bready,

  output logic                 out_arvalid,
  output logic [ADDR_W-1:0]    out_araddr,
  output logic [ID_W-1:0]      out_arid,
  output logic [LEN_W-1:0]     out_arlen,
  output logic [SIZE_W-1:0]    out_arsize,
  output logic [BURST_W-1:0]   out_arburst,
  input  logic                 out_arready,
  output logic                 out_awvalid,
  output logic [ADDR_W-1:0]    out_awaddr,
  output logic [ID_W-1:0]      out_awid,
  output logic [LEN_W-1:0]     out_awlen,
  output logic [SIZE_W-1:0]    out_awsize,
  output logic [BURST_W-1:0]   out_awburst,
  input  logic                 out_awready,
  output logic                 out_wvalid,
  output logic [DATA_W-1:0]    out_wdata,
  output logic [STRB_W-1:0]    out_wstrb,
  output logic                 out_wlast,
  input  logic                 out_wready,
  input  logic                 out_rvalid,
  input  logic [DATA_W-1:0]    out_rdata,
  input  logic [RESP_W-1:0]    out_rresp,
  input  logic [ID_W-1:0]      out_rid,
  input  logic                 out_rlast,
  output logic                 out_rready,
  input  logic                 out_bvalid,
  input  logic [RESP_W-1:0]    out_bresp,
  input  logic [ID_W-1:0]      out_bid,
  output logic                 out_bready
);

  arb_state_e state, state_nxt;
  logic       rr_last, rr_last_nxt;
  logic       a_done, a_done_nxt;
  logic       w_done, w_done_nxt;
  logic       lsu_req;
  logic [1:0] gnt;
  logic       rd_lsu;

  assign lsu_req = lsu_awvalid | lsu_arvalid;

  ysyx_25040109_rr_pick2 u_pick (
    .req  ({lsu_req, ifu_arvalid}),
    .last (rr_last),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      a_done  <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
      a_done  <= a_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Payloads are muxed unconditionally; only the valids/readies carry meaning
  assign rd_lsu      = (state == LSU_RD);
  assign out_araddr  = rd_lsu ? lsu_araddr  : ifu_araddr;
  assign out_arid    = rd_lsu ? lsu_arid    : ifu_arid;
  assign out_arlen   = rd_lsu ? lsu_arlen   : ifu_arlen;
  assign out_arsize  = rd_lsu ? lsu_arsize  : ifu_arsize;
  assign out_arburst = rd_lsu ? lsu_arburst : ifu_arburst;

  assign out_awaddr  = lsu_awaddr;
  assign out_awid    = lsu_awid;
  assign out_awlen   = lsu_awlen;
  assign out_awsize  = lsu_awsize;
  assign out_awburst = lsu_awburst;
  assign out_wdata   = lsu_wdata;
  assign out_wstrb   = lsu_wstrb;
  assign out_wlast   = lsu_wlast;

  assign ifu_rdata = out_rdata;
  assign ifu_rresp = out_rresp;
  assign ifu_rid   = out_rid;
  assign ifu_rlast = out_rlast;
  assign lsu_rdata = out_rdata;
  assign lsu_rresp = out_rresp;
  assign lsu_rid   = out_rid;
  assign lsu_rlast = out_rlast;
  assign lsu_bresp = out_bresp;
  assign lsu_bid   = out_bid;

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    a_done_nxt  = a_done;
    w_done_nxt  = w_done;
    out_arvalid = 1'b0;
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_rready  = 1'b0;
    out_bready  = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;

    case (state)
      IDLE: begin
        if (gnt[0]) begin
          state_nxt   = IFU_RD;
          rr_last_nxt = 1'b0;
          a_done_nxt  = 1'b0;
          w_done_nxt  = 1'b0;
        end else if (gnt[1]) begin
          // A pending write beats a pending read from the same master
          state_nxt   = lsu_awvalid ? LSU_WR : LSU_RD;
          rr_last_nxt = 1'b1;
          a_done_nxt  = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end

      IFU_RD: begin
        out_arvalid = ifu_arvalid & ~a_done;
        ifu_arready = out_arready & ~a_done;
        if (out_arvalid && out_arready) a_done_nxt = 1'b1;
        ifu_rvalid  = out_rvalid;
        out_rready  = ifu_rready;
        if (out_rvalid && out_rready && out_rlast) state_nxt = IDLE;
      end

      LSU_RD: begin
        out_arvalid = lsu_arvalid & ~a_done;
        lsu_arready = out_arready & ~a_done;
        if (out_arvalid && out_arready) a_done_nxt = 1'b1;
        lsu_rvalid  = out_rvalid;
        out_rready  = lsu_rready;
        if (out_rvalid && out_rready && out_rlast) state_nxt = IDLE;
      end

      LSU_WR: begin
        out_awvalid = lsu_awvalid & ~a_done;
        lsu_awready = out_awready & ~a_done;
        if (out_awvalid && out_awready) a_done_nxt = 1'b1;
        out_wvalid  = lsu_wvalid & ~w_done;
        lsu_wready  = out_wready & ~w_done;
        if (out_wvalid && out_wready && lsu_wlast) w_done_nxt = 1'b1;
        lsu_bvalid  = out_bvalid;
        out_bready  = lsu_bready;
        if (out_bvalid && out_bready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
